// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and buffer-select helper for the ifmap row loader.
package conv_pkg;

  localparam int unsigned PIXELS_IN_ROW = 32;
  localparam int unsigned BEAT_PIXELS   = 8;
  localparam int unsigned NUM_BUFS      = 3;
  localparam int unsigned PIX_W         = 8;
  localparam int unsigned DIM_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

  // One-hot row-buffer strobe for buffer index sel (0..NUM_BUFS-1).
  function automatic logic [NUM_BUFS-1:0] buf_onehot(input logic [1:0] sel);
    return NUM_BUFS'(1) << sel;
  endfunction

endpackage

// File: rtl/beat_packer.sv
// Assembles input beats into one row-buffer word and flags the completing beat.
// IFMAP_LOADER_ZERO_PAD_EN: when defined, lanes past the row end are written as zero.
module beat_packer
  import conv_pkg::*;
#(
  parameter int unsigned PIXELS_IN_ROW = conv_pkg::PIXELS_IN_ROW,
  parameter int unsigned BEAT_PIXELS   = conv_pkg::BEAT_PIXELS,
  localparam int unsigned WORD_BEATS   = PIXELS_IN_ROW / BEAT_PIXELS,
  localparam int unsigned SLOT_W       = (WORD_BEATS > 1) ? $clog2(WORD_BEATS) : 1,
  localparam int unsigned CNT_W        = $clog2(BEAT_PIXELS + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clr_i,
  input  logic                              beat_i,
  input  logic                              row_last_i,
  input  logic [CNT_W-1:0]                  vcnt_i,
  input  logic [BEAT_PIXELS*PIX_W-1:0]      pix_i,
  output logic [PIXELS_IN_ROW*PIX_W-1:0]    word_o,
  output logic                              word_cmpl_c
);

`ifdef IFMAP_LOADER_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  logic [SLOT_W-1:0]               slot_q, slot_d;
  logic [PIXELS_IN_ROW*PIX_W-1:0]  word_q, word_d;

  assign word_cmpl_c = beat_i && (row_last_i || (slot_q == SLOT_W'(WORD_BEATS - 1)));

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (beat_i) begin
      slot_d = word_cmpl_c ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // Each word lane takes the beat lane of its slot when in range; out-of-row lanes hold or pad.
  for (genvar p = 0; p < PIXELS_IN_ROW; p++) begin : g_lane
    localparam int unsigned SLOT = p / BEAT_PIXELS;
    localparam int unsigned LANE = p % BEAT_PIXELS;
    logic hit, pad;
    assign hit = beat_i && (slot_q == SLOT_W'(SLOT)) && (vcnt_i > CNT_W'(LANE));
    assign pad = ZERO_PAD && beat_i && row_last_i && (SLOT_W'(SLOT) >= slot_q);
    assign word_d[p*PIX_W +: PIX_W] = hit ? pix_i[LANE*PIX_W +: PIX_W] :
                                      (pad ? '0 : word_q[p*PIX_W +: PIX_W]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q <= '0;
      word_q <= '0;
    end else begin
      slot_q <= slot_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/ifmap_row_loader.sv
// Streams input-map rows into three rotating row buffers, one packed word per write.
// IFMAP_LOADER_ZERO_PAD_EN: when defined, word lanes past the row end are written as zero.
module ifmap_row_loader
  import conv_pkg::*;
#(
  parameter int unsigned PIXELS_IN_ROW = conv_pkg::PIXELS_IN_ROW,
  parameter int unsigned BEAT_PIXELS   = conv_pkg::BEAT_PIXELS,
  parameter int unsigned ADR_W         = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DIM_W-1:0]                  ix,
  input  logic [DIM_W-1:0]                  iy,
  input  logic [DIM_W-1:0]                  nif,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BEAT_PIXELS*PIX_W-1:0]      in_pixels,
  output logic [NUM_BUFS-1:0]               wr_en,
  output logic [ADR_W-1:0]                  wr_adr,
  output logic [PIXELS_IN_ROW*PIX_W-1:0]    wr_data,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned CNT_W = $clog2(BEAT_PIXELS + 1);

  ld_state_e state_q, state_d;
  logic in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;

  logic [DIM_W-1:0]    ix_q, ix_d, iy_q, iy_d, nif_q, nif_d;
  logic [DIM_W-1:0]    x_q, x_d, y_q, y_d, map_q, map_d;
  logic [1:0]          sel_q, sel_d;
  logic [ADR_W-1:0]    adr_q [NUM_BUFS];
  logic [ADR_W-1:0]    adr_d [NUM_BUFS];
  logic [NUM_BUFS-1:0] wr_en_q, wr_en_d;
  logic [ADR_W-1:0]    wr_adr_q, wr_adr_d;

  logic             start_ok, accept, row_last, y_last, map_last, final_beat, word_cmpl;
  logic [CNT_W-1:0] vcnt;

  assign start_ok   = (state_q == ST_IDLE) && start;
  assign accept     = in_valid && in_ready_q;
  assign row_last   = ((DIM_W+1)'(x_q) + (DIM_W+1)'(BEAT_PIXELS)) >= (DIM_W+1)'(ix_q);
  assign y_last     = (y_q == iy_q - DIM_W'(1));
  assign map_last   = (map_q == nif_q - DIM_W'(1));
  assign final_beat = accept && row_last && y_last && map_last;
  assign vcnt       = row_last ? CNT_W'(ix_q - x_q) : CNT_W'(BEAT_PIXELS);

  beat_packer #(
    .PIXELS_IN_ROW (PIXELS_IN_ROW),
    .BEAT_PIXELS   (BEAT_PIXELS)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (start_ok),
    .beat_i      (accept),
    .row_last_i  (row_last),
    .vcnt_i      (vcnt),
    .pix_i       (in_pixels),
    .word_o      (wr_data),
    .word_cmpl_c (word_cmpl)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (final_beat) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Flags decode the next state so the registered outputs line up with the state.
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      ST_LOAD:  begin in_ready_d = 1'b1; busy_d = 1'b1; end
      ST_FLUSH: busy_d = 1'b1;
      ST_DONE:  begin busy_d = 1'b1; done_d = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    ix_d     = ix_q;
    iy_d     = iy_q;
    nif_d    = nif_q;
    x_d      = x_q;
    y_d      = y_q;
    map_d    = map_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    wr_en_d  = '0;
    wr_adr_d = wr_adr_q;
    if (start_ok) begin
      ix_d  = ix;
      iy_d  = iy;
      nif_d = nif;
      x_d   = '0;
      y_d   = '0;
      map_d = '0;
      sel_d = '0;
      for (int b = 0; b < NUM_BUFS; b++) adr_d[b] = '0;
    end else if (accept) begin
      if (row_last) begin
        x_d   = '0;
        sel_d = (sel_q == 2'(NUM_BUFS - 1)) ? 2'd0 : sel_q + 2'd1;
        if (y_last) begin
          y_d   = '0;
          map_d = map_q + DIM_W'(1);
        end else begin
          y_d = y_q + DIM_W'(1);
        end
      end else begin
        x_d = x_q + DIM_W'(BEAT_PIXELS);
      end
    end
    // The word closes on this beat and is written to the current row's buffer next cycle.
    if (word_cmpl) begin
      wr_en_d       = buf_onehot(sel_q);
      wr_adr_d      = adr_q[sel_q];
      adr_d[sel_q]  = adr_q[sel_q] + ADR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ix_q       <= '0;
      iy_q       <= '0;
      nif_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      map_q      <= '0;
      sel_q      <= '0;
      adr_q      <= '{default: '0};
      wr_en_q    <= '0;
      wr_adr_q   <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ix_q       <= ix_d;
      iy_q       <= iy_d;
      nif_q      <= nif_d;
      x_q        <= x_d;
      y_q        <= y_d;
      map_q      <= map_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      wr_en_q    <= wr_en_d;
      wr_adr_q   <= wr_adr_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_en    = wr_en_q;
  assign wr_adr   = wr_adr_q;

endmodule

// File: tb/tb_ifmap_row_loader.sv
// Scoreboard bench for ifmap_row_loader: a row/word model queues expected writes, a monitor checks them.
module tb_ifmap_row_loader;

  localparam int unsigned PIR   = 32;
  localparam int unsigned BP    = 8;
  localparam int unsigned ADR_W = 3;
  localparam int unsigned PW    = PIR * 8;
  localparam int unsigned BW    = BP * 8;
  localparam int          LIMIT = 4000;

`ifdef IFMAP_LOADER_ZERO_PAD_EN
  localparam bit ZPAD = 1'b1;
`else
  localparam bit ZPAD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, start, in_valid, in_ready, busy, done;
  logic [15:0]      ix, iy, nif;
  logic [BW-1:0]    in_pixels;
  logic [2:0]       wr_en;
  logic [ADR_W-1:0] wr_adr;
  logic [PW-1:0]    wr_data;

  always #5 clk = ~clk;

  ifmap_row_loader #(
    .PIXELS_IN_ROW (PIR),
    .BEAT_PIXELS   (BP),
    .ADR_W         (ADR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ix        (ix),
    .iy        (iy),
    .nif       (nif),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixels (in_pixels),
    .wr_en     (wr_en),
    .wr_adr    (wr_adr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [2:0]       en;
    logic [ADR_W-1:0] adr;
    logic [PW-1:0]    data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  mreg [PIR];
  int unsigned madr [3];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int seed, input int idx);
    case (mode)
      0:       return 8'(idx);
      1:       return 8'hFF;
      default: return 8'((idx * 37 + seed * 101) ^ (idx >> 5));
    endcase
  endfunction

  // Monitor: every write strobe must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mon_en && wr_en != 3'b000) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=wr_en %b adr %0d required=no write", wr_en, wr_adr);
        end else begin
          e = exp_q.pop_front();
          check("wr_en", PW'(wr_en), PW'(e.en));
          check("wr_adr", PW'(wr_adr), PW'(e.adr));
          check("wr_data", wr_data, e.data);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, PW'(wr_en), '0);
    check({tag, "_wr_adr"}, PW'(wr_adr), '0);
    check({tag, "_wr_data"}, wr_data, '0);
    check({tag, "_in_ready"}, PW'(in_ready), '0);
    check({tag, "_busy"}, PW'(busy), '0);
    check({tag, "_done"}, PW'(done), '0);
  endtask

  task automatic model_reset();
    for (int l = 0; l < PIR; l++) mreg[l] = 8'h00;
    for (int b = 0; b < 3; b++) madr[b] = 0;
  endtask

  task automatic run_job(input int ixv, input int iyv, input int nifv, input int mode, input int seed,
                         input int bubble, input int start_at, input int abort_at);
    logic [BW-1:0] beats[$];
    logic [BW-1:0] bt;
    logic [PW-1:0] wd;
    wr_t           e;
    int nb, nw, n, g, base, sent, cyc, stalls;
    bit acc, start_sent;
    nb = (ixv + BP - 1) / BP;
    nw = (ixv + PIR - 1) / PIR;
    for (int b = 0; b < 3; b++) madr[b] = 0;
    // Expected writes: each row split into PIR-pixel words, buffer g mod 3.
    for (int m = 0; m < nifv; m++) begin
      for (int y = 0; y < iyv; y++) begin
        g    = m * iyv + y;
        base = g * ixv;
        for (int w = 0; w < nw; w++) begin
          n = (ixv - w * PIR < PIR) ? ixv - w * PIR : PIR;
          for (int l = 0; l < PIR; l++) begin
            if (l < n) mreg[l] = pix(mode, seed, base + w * PIR + l);
            else if (ZPAD) mreg[l] = 8'h00;
          end
          for (int l = 0; l < PIR; l++) wd[l*8 +: 8] = mreg[l];
          e.en   = 3'(1) << (g % 3);
          e.adr  = ADR_W'(madr[g % 3]);
          e.data = wd;
          exp_q.push_back(e);
          madr[g % 3]++;
        end
        for (int b = 0; b < nb; b++) begin
          for (int l = 0; l < BP; l++) begin
            if (b * BP + l < ixv) bt[l*8 +: 8] = pix(mode, seed, base + b * BP + l);
            else bt[l*8 +: 8] = 8'($urandom);
          end
          beats.push_back(bt);
        end
      end
    end

    @(posedge clk); #1;
    check("busy_before_start", PW'(busy), '0);
    ix = 16'(ixv); iy = 16'(iyv); nif = 16'(nifv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", PW'(busy), PW'(1));
    check("ready_after_start", PW'(in_ready), PW'(1));

    sent = 0; cyc = 0; stalls = 0; start_sent = 1'b0;
    while (sent < beats.size() && cyc < LIMIT && !(abort_at > 0 && sent == abort_at)) begin
      in_valid  = (int'($urandom_range(99)) >= bubble);
      in_pixels = beats[sent];
      if (!start_sent && sent == start_at) begin
        start      = 1'b1;
        start_sent = 1'b1;
      end
      @(negedge clk);
      if (in_valid && !in_ready) stalls++;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    check("ready_no_stall", PW'(stalls), '0);

    if (abort_at > 0) begin
      check("beats_before_abort", PW'(sent), PW'(abort_at));
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
      model_reset();
      check_idle_outputs("abort");
      repeat (4) @(posedge clk);
      #1;
      return;
    end

    check("beats_sent", PW'(sent), PW'(beats.size()));
    @(negedge clk);
    check("flush_ready", PW'(in_ready), '0);
    check("flush_done", PW'(done), '0);
    check("flush_busy", PW'(busy), PW'(1));
    @(negedge clk);
    check("done_pulse", PW'(done), PW'(1));
    check("done_busy", PW'(busy), PW'(1));
    @(negedge clk);
    check("done_clear", PW'(done), '0);
    check("idle_busy", PW'(busy), '0);
    check("writes_left", PW'(exp_q.size()), '0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixels = '0;
    ix = '0; iy = '0; nif = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset  = 1'b1;
    mon_en = 1'b1;

    run_job(32, 3, 1, 0, 0, 0, -1, 0);
    run_job(64, 4, 2, 2, 1, 0, -1, 0);
    run_job(20, 1, 1, 1, 0, 0, -1, 0);
    run_job(40, 5, 1, 2, 7, 0, -1, 0);
    run_job(40, 5, 1, 2, 7, 50, -1, 0);
    run_job(48, 2, 2, 2, 9, 25, 3, 0);
    run_job(64, 2, 1, 2, 11, 0, -1, 5);
    run_job(64, 1, 1, 2, 12, 0, -1, 0);
    run_job(1, 2, 2, 2, 13, 0, -1, 0);
    run_job(256, 4, 1, 2, 14, 10, -1, 0);
    for (int k = 0; k < 6; k++) begin
      run_job(int'($urandom_range(100, 1)), int'($urandom_range(4, 1)), int'($urandom_range(3, 1)),
              2, k + 20, int'($urandom_range(60, 0)), -1, 0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
